// File: rtl/ace_txn_ctrl.sv
// ace_txn_ctrl: ACE master-side control for ReadShared/MakeUnique/WriteClean with retries and a buffered snoop path.
// Optional watchdog on BRESP/RDATA/SNP_LOOK enabled by defining ACE_TIMEOUT_EN.
module ace_txn_ctrl #(
  parameter int BURST_LEN = 4,
  parameter int MAX_RETRY = 3,
  parameter int SNP_DEPTH = 2,
  parameter int TO_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic read_req,
  input  logic write_req,
  input  logic invalid_req,
  output logic ace_ready,
  output logic ace_err,
  output logic read_shared_o,
  output logic make_unique_o,
  output logic write_clean_o,
  input  logic resp_okay,
  output logic beat_en,
  output logic read_resp_en,
  output logic AW_VALID,
  input  logic AW_READY,
  output logic W_VALID,
  input  logic W_READY,
  output logic W_LAST,
  input  logic B_VALID,
  output logic B_READY,
  output logic AR_VALID,
  input  logic AR_READY,
  input  logic R_VALID,
  output logic R_READY,
  input  logic R_LAST,
  input  logic AC_VALID,
  output logic AC_READY,
  output logic CR_VALID,
  input  logic CR_READY,
  output logic CD_VALID,
  input  logic CD_READY,
  output logic CD_LAST,
  output logic snp_push,
  output logic snp_pop,
  input  logic snp_done,
  input  logic snp_data
);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int OW = $clog2(SNP_DEPTH + 1);
  localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);
  localparam logic [RW-1:0] MAXR = RW'(MAX_RETRY);
  typedef enum logic [2:0] {IDLE, WADDR, WDATA, BRESP, RADDR, RDATA, SNP_LOOK, SNP_RESP} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [OW-1:0] occ_q, occ_d;
  logic mu_q, mu_d, fail_q, fail_d, sdata_q, sdata_d, cr_q, cr_d, cd_q, cd_d;
  logic to;
  // Gated by rst_n so every output reads 0 while reset is held.
  assign AC_READY = rst_n & (occ_q < OW'(SNP_DEPTH));
  assign snp_push = AC_VALID & AC_READY;
  assign snp_pop = (state_q == IDLE) & (occ_q != '0);
  assign occ_d = occ_q + OW'(snp_push) - OW'(snp_pop);
  assign read_shared_o = AR_VALID & ~mu_q;
  assign make_unique_o = AR_VALID & mu_q;
  assign write_clean_o = AW_VALID;
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    retry_d = retry_q;
    mu_d = mu_q;
    fail_d = fail_q;
    sdata_d = sdata_q;
    cr_d = cr_q;
    cd_d = cd_q;
    ace_ready = 1'b0;
    ace_err = 1'b0;
    read_resp_en = 1'b0;
    beat_en = 1'b0;
    AW_VALID = 1'b0;
    W_VALID = 1'b0;
    W_LAST = 1'b0;
    B_READY = 1'b0;
    AR_VALID = 1'b0;
    R_READY = 1'b0;
    CR_VALID = 1'b0;
    CD_VALID = 1'b0;
    CD_LAST = 1'b0;
    case (state_q)
      IDLE: begin
        if (occ_q != '0) state_d = SNP_LOOK;
        else if (write_req) begin
          state_d = WADDR;
          retry_d = '0;
        end else if (invalid_req | read_req) begin
          state_d = RADDR;
          retry_d = '0;
          mu_d = invalid_req;
        end
      end
      WADDR: begin
        AW_VALID = 1'b1;
        if (AW_READY) begin
          state_d = WDATA;
          beat_d = '0;
        end
      end
      WDATA: begin
        W_VALID = 1'b1;
        W_LAST = beat_q == LAST;
        beat_en = W_READY;
        if (W_READY) begin
          beat_d = beat_q + BW'(1);
          if (W_LAST) state_d = BRESP;
        end
      end
      BRESP: begin
        B_READY = 1'b1;
        if (B_VALID) begin
          if (resp_okay) begin
            ace_ready = 1'b1;
            state_d = IDLE;
          end else if (retry_q < MAXR) begin
            retry_d = retry_q + RW'(1);
            state_d = WADDR;
          end else begin
            ace_err = 1'b1;
            state_d = IDLE;
          end
        end else if (to) begin
          ace_err = 1'b1;
          state_d = IDLE;
        end
      end
      RADDR: begin
        AR_VALID = 1'b1;
        if (AR_READY) begin
          state_d = RDATA;
          beat_d = '0;
          fail_d = 1'b0;
        end
      end
      RDATA: begin
        R_READY = 1'b1;
        beat_en = R_VALID;
        if (R_VALID) begin
          beat_d = beat_q + BW'(1);
          fail_d = fail_q | ~resp_okay;
          if (R_LAST) begin
            if (!fail_d) begin
              ace_ready = 1'b1;
              read_resp_en = 1'b1;
              state_d = IDLE;
            end else if (retry_q < MAXR) begin
              retry_d = retry_q + RW'(1);
              state_d = RADDR;
            end else begin
              ace_err = 1'b1;
              state_d = IDLE;
            end
          end
        end else if (to) begin
          ace_err = 1'b1;
          state_d = IDLE;
        end
      end
      SNP_LOOK: begin
        if (snp_done | to) begin
          sdata_d = snp_done & snp_data;
          state_d = SNP_RESP;
          beat_d = '0;
          cr_d = 1'b0;
          cd_d = 1'b0;
        end
      end
      default: begin
        CR_VALID = ~cr_q;
        CD_VALID = sdata_q & ~cd_q;
        CD_LAST = CD_VALID & (beat_q == LAST);
        if (CD_VALID & CD_READY) beat_d = beat_q + BW'(1);
        cr_d = cr_q | CR_READY;
        cd_d = cd_q | ~sdata_q | (CD_VALID & CD_READY & CD_LAST);
        if (cr_d & cd_d) state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q <= '0;
      retry_q <= '0;
      occ_q <= '0;
      mu_q <= 1'b0;
      fail_q <= 1'b0;
      sdata_q <= 1'b0;
      cr_q <= 1'b0;
      cd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      retry_q <= retry_d;
      occ_q <= occ_d;
      mu_q <= mu_d;
      fail_q <= fail_d;
      sdata_q <= sdata_d;
      cr_q <= cr_d;
      cd_q <= cd_d;
    end
  end
`ifdef ACE_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);
  logic [TW-1:0] wd_q, wd_d;
  logic wait_st, prog;
  // Counter restarts on any progress or when leaving a waiting state.
  always_comb begin
    wait_st = (state_q == BRESP) | (state_q == RDATA) | (state_q == SNP_LOOK);
    prog = ((state_q == BRESP) & B_VALID) | ((state_q == RDATA) & R_VALID) | ((state_q == SNP_LOOK) & snp_done);
    to = wait_st & ~prog & (wd_q == TW'(TO_CYCLES));
    wd_d = (wait_st & ~prog & ~to) ? wd_q + TW'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else wd_q <= wd_d;
  end
`else
  assign to = 1'b0 & (TO_CYCLES > 0);
`endif
endmodule

// File: doc/ace_txn_ctrl.md
Name: ace_txn_ctrl

Overview:
Parametrised next-generation ACE master-side transaction controller between the cache controller and the ACE interconnect port. Sequences ReadShared/MakeUnique (AR/R) and WriteClean (AW/W/B) with multi-beat bursts and a bounded retry count. Queues incoming snoops (AC) in a small occupancy-tracked buffer so they are accepted while a bus transaction is in flight. Answers snoops on CR/CD with multi-beat snoop data. Address/data storage is in the datapath; this block is control only.

Parameters:
BURST_LEN, 4, beats per cache line on W, R and CD (>=1)
MAX_RETRY, 3, re-issues after a non-OKAY response before reporting an error (>=0)
SNP_DEPTH, 2, snoop buffer entries (>=1)
TO_CYCLES, 256, watchdog limit in cycles (used only with ACE_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
read_req / write_req / invalid_req  in  1 each  cache request; level, held until ace_ready or ace_err
ace_ready  out  1  one-cycle pulse: request completed OKAY
ace_err  out  1  one-cycle pulse: request abandoned (retries exhausted or timeout)
read_shared_o / make_unique_o / write_clean_o  out  1 each  transaction type to datapath; high while AR_VALID/AW_VALID asserted for that type
resp_okay  in  1  datapath decode of BRESP/RRESP = OKAY, valid with B_VALID or R_VALID
beat_en  out  1  W or R handshake this cycle; datapath advances beat index
read_resp_en  out  1  pulse on final OKAY R beat
AW_VALID, AW_READY, W_VALID, W_READY, W_LAST, B_VALID, B_READY  ACE write channels (VALID/LAST out, READY in; B_VALID in, B_READY out)
AR_VALID, AR_READY, R_VALID, R_READY, R_LAST  ACE read channels (R_LAST in)
AC_VALID in, AC_READY out; CR_VALID out, CR_READY in; CD_VALID out, CD_READY in, CD_LAST out
snp_push  out  1  AC handshake; datapath stores AC address at its write pointer
snp_pop  out  1  head snoop entering lookup; datapath advances read pointer
snp_done  in  1  datapath lookup finished (may come any cycle after snp_pop)
snp_data  in  1  with snp_done: hit on dirty line, data transfer needed

Behaviour:
- Reset: all outputs 0, state IDLE, retry/beat/occupancy counters 0. Reset mid-operation drops everything, no completion pulse.
- AC_READY = (occupancy < SNP_DEPTH), independent of FSM state; snp_push = AC_VALID & AC_READY. Occupancy +1 on push, -1 on pop; simultaneous push+pop leaves it unchanged. Full -> AC_READY=0 that cycle.
- States: IDLE, WADDR, WDATA, BRESP, RADDR, RDATA, SNP_LOOK, SNP_RESP.
- IDLE priority: snoop buffer non-empty > write_req > invalid_req > read_req. Snoop: snp_pop=1, -> SNP_LOOK. Request: retry counter=0, -> WADDR or RADDR; VALID asserted from the following cycle.
- WADDR: AW_VALID=1 until AW_READY -> WDATA, beat=0. WDATA: W_VALID=1; each W_READY increments beat; W_LAST=1 when beat==BURST_LEN-1; handshake with last -> BRESP.
- BRESP: B_READY=1. On B_VALID: okay -> ace_ready, IDLE; else retry<MAX_RETRY -> retry+1, WADDR; else ace_err, IDLE.
- RADDR/RDATA analogous: R_READY=1 in RDATA, beat_en per R handshake. resp_okay sampled per beat; any non-OKAY beat latches a sticky fail. R_LAST beat: no fail -> ace_ready+read_resp_en; fail -> retry/err as BRESP. R_LAST earlier/later than BURST_LEN is trusted (R_LAST ends burst).
- SNP_LOOK: wait snp_done; latch snp_data, -> SNP_RESP. SNP_RESP: CR_VALID=1 until CR_READY; if snp_data, CD_VALID=1 concurrently for BURST_LEN beats, CD_LAST on final; CR and CD complete independently; leave to IDLE when both done.
- VALID never drops before READY (AXI stability). Request signals changing mid-transaction are ignored until return to IDLE.
- Latency: idle request to AR_VALID/AW_VALID = 1 cycle; zero-wait read of BURST_LEN beats completes in BURST_LEN+2 cycles.

Optional Feature:
ACE_TIMEOUT_EN: defined -> watchdog counts cycles spent in any one of BRESP, RDATA, SNP_LOOK without progress (handshake/snp_done resets it); at TO_CYCLES: BRESP/RDATA -> ace_err, IDLE; SNP_LOOK -> SNP_RESP with snp_data=0. Undefined -> no counter, states wait indefinitely.

Test Plan:
- read_req, AR_READY=1, 4 OKAY R beats no stalls -> AR_VALID cycle 1, read_resp_en+ace_ready on beat 4, total 6 cycles.
- write_req, W_READY toggling 1/0, B okay -> W_LAST exactly on 4th W handshake, one ace_ready.
- read with RRESP=SLVERR every attempt, MAX_RETRY=3 -> 4 AR handshakes, then one ace_err, no ace_ready.
- 3 AC_VALID back-to-back during a write, SNP_DEPTH=2 -> 2 pushes, AC_READY=0 on third until first pop; snoops serviced before a pending read_req.
- snoop with snp_data=1, CR_READY=1, CD_READY stalls 2 cycles -> CR done first, 4 CD beats, CD_LAST on 4th, then IDLE.
- ACE_TIMEOUT_EN, TO_CYCLES=16, B_VALID never -> ace_err 16 cycles after BRESP entry; rst_n low mid-burst -> all outputs 0 next cycle.
